// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first, one bit per clock).
// Optional SERSUB_BORROW_IN_EN adds a borrow_in port for multi-word chaining.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERSUB_BORROW_IN_EN
  input  logic             borrow_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] res_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;
  logic             d_s;
  logic             br_next_s;
  logic             br_init_s;

  // Full-subtractor cell: returns {difference, borrow}.
  function automatic logic [1:0] fsub(input logic x, input logic y, input logic bin);
    logic dd;
    logic bo;
    dd = x ^ y ^ bin;
    bo = (~x & y) | (~(x ^ y) & bin);
    return {dd, bo};
  endfunction

`ifdef SERSUB_BORROW_IN_EN
  assign br_init_s = borrow_in;
`else
  assign br_init_s = 1'b0;
`endif

  // Current bit result and outgoing borrow from the low operand bits.
  always_comb begin
    {d_s, br_next_s} = fsub(sa_r[0], sb_r[0], br_r);
  end

  // Control FSM, operand shifters, result shifter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      sa_r       <= {WIDTH{1'b0}};
      sb_r       <= {WIDTH{1'b0}};
      res_r      <= {WIDTH{1'b0}};
      br_r       <= 1'b0;
      cnt_r      <= CNT_ZERO;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= {WIDTH{1'b0}};
      borrow_out <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa_r    <= a;
            sb_r    <= b;
            br_r    <= br_init_s;
            cnt_r   <= CNT_ZERO;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
          sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
          res_r <= {d_s, res_r[WIDTH-1:1]};
          br_r  <= br_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          // Last bit: publish the result; diff/borrow_out hold until the next final edge.
          if (cnt_r == CNT_LAST) begin
            diff       <= {d_s, res_r[WIDTH-1:1]};
            borrow_out <= br_next_s;
            busy       <= 1'b0;
            done       <= 1'b1;
            state_r    <= DONE;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            sa_r    <= a;
            sb_r    <= b;
            br_r    <= br_init_s;
            cnt_r   <= CNT_ZERO;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       borrow_in;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;

  int vectors;
  int miscompares;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SERSUB_BORROW_IN_EN
    .borrow_in (borrow_in),
`endif
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one edge; returns just after the load edge.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    borrow_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    vectors++;
    if ({busy, done, diff, borrow_out} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b diff=%h borrow=%b, required all 0", busy, done, diff, borrow_out);
    end
    step();
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_subtract(input logic [7:0] av, input logic [7:0] bv,
                               input logic [7:0] exp_d, input logic exp_b);
    int n;
    int bc;
    launch(av, bv);
    n = 0;
    bc = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) bc++;
      step();
      n++;
    end
    vectors++;
    if (n !== 8) begin
      miscompares++;
      $display("FAIL latency %h-%h: done after %0d edges, required 8", av, bv, n);
    end
    vectors++;
    if (bc !== 8) begin
      miscompares++;
      $display("FAIL busy_len %h-%h: busy %0d cycles, required 8", av, bv, bc);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_at_done %h-%h: busy=%b, required 0", av, bv, busy);
    end
    vectors++;
    if (diff !== exp_d) begin
      miscompares++;
      $display("FAIL diff %h-%h: got %h, required %h", av, bv, diff, exp_d);
    end
    vectors++;
    if (borrow_out !== exp_b) begin
      miscompares++;
      $display("FAIL borrow %h-%h: got %b, required %b", av, bv, borrow_out, exp_b);
    end
    step();
    vectors++;
    if (done !== 1'b0 || diff !== exp_d) begin
      miscompares++;
      $display("FAIL done_pulse %h-%h: done=%b diff=%h, required 0 %h", av, bv, done, diff, exp_d);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    launch(8'hC3, 8'h35);
    step();
    step();
    a     = 8'h00;
    b     = 8'hFF;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 3;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (n !== 8) begin
      miscompares++;
      $display("FAIL ignore_latency: done after %0d edges, required 8", n);
    end
    vectors++;
    if (diff !== 8'h8E || borrow_out !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_result: diff=%h borrow=%b, required 8e 0", diff, borrow_out);
    end
    step();
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL ignore_no_restart: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    launch(8'h5A, 8'h3C);
    step();
    step();
    step();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_run_busy: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    vectors++;
    if ({busy, done, diff, borrow_out} !== 11'd0) begin
      miscompares++;
      $display("FAIL mid_run_reset: busy=%b done=%b diff=%h borrow=%b, required all 0", busy, done, diff, borrow_out);
    end
    step();
    step();
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL mid_run_idle: busy=%b done=%b, required 0 0", busy, done);
    end
    test_subtract(8'h20, 8'h05, 8'h1B, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    a     = 8'h10;
    b     = 8'h01;
    start = 1'b1;
    step();
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (done !== 1'b1 || diff !== 8'h0F || borrow_out !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first: done=%b diff=%h borrow=%b, required 1 0f 0", done, diff, borrow_out);
    end
    a = 8'h01;
    b = 8'h02;
    step();
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1 && done === 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL b2b_overlap: busy=1 done=1, required not both");
      end
      step();
      n++;
    end
    vectors++;
    if (n !== 9) begin
      miscompares++;
      $display("FAIL b2b_spacing: done pulses %0d cycles apart, required 9", n);
    end
    vectors++;
    if (diff !== 8'hFF || borrow_out !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: diff=%h borrow=%b, required ff 1", diff, borrow_out);
    end
    start = 1'b0;
    step();
    step();
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

`ifdef SERSUB_BORROW_IN_EN
  task automatic test_borrow_in();
    borrow_in = 1'b1;
    test_subtract(8'h10, 8'h01, 8'h0E, 1'b0);
    test_subtract(8'h00, 8'h00, 8'hFF, 1'b1);
    borrow_in = 1'b0;
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_subtract(8'h5A, 8'h3C, 8'h1E, 1'b0);
    test_subtract(8'h00, 8'h01, 8'hFF, 1'b1);
    test_subtract(8'h80, 8'h80, 8'h00, 1'b0);
    test_subtract(8'hFF, 8'h00, 8'hFF, 1'b0);
    test_subtract(8'h7F, 8'hFE, 8'h81, 1'b1);
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERSUB_BORROW_IN_EN
    test_borrow_in();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `diff = a - b` (two's-complement wrap, borrow flag) one bit per clock, LSB first, through a single full-subtractor cell plus a registered borrow. It sits in the arithmetic datapath of the lab system directly downstream of operand capture. It consumes one full-subtractor bit result per cycle and feeds results to the display/compare stage. It trades WIDTH cycles of latency for a single 1-bit subtractor slice.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk  in  1`: rising-edge clock.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: request to begin a subtraction; sampled on rising edge.
- `a  in  WIDTH`: minuend; captured on the accepted `start` edge only.
- `b  in  WIDTH`: subtrahend; captured on the accepted `start` edge only.
- `busy  out  1`: high while bits are being processed (RUN).
- `done  out  1`: one-cycle pulse when `diff`/`borrow_out` become valid.
- `diff  out  WIDTH`: result `a - b` mod 2^WIDTH.
- `borrow_out  out  1`: final borrow; 1 if and only if `a < b` (unsigned), or `a < b + borrow_in` with the macro enabled.
- `borrow_in  in  1`: present only when `SERSUB_BORROW_IN_EN` is defined (see Configuration).

One clock; reset is synchronous and active-high.

## Operation
- **State machine**: IDLE, RUN, DONE.
- **IDLE**
  - If `start` is high: load shift registers `sa<=a`, `sb<=b`, borrow register `br<=0`, bit counter `cnt<=0`, then go to RUN.
  - Otherwise stay in IDLE.
- **RUN**, each cycle:
  - Bit cell: `d = sa[0] ^ sb[0] ^ br`; `br_next = (~sa[0] & sb[0]) | (~(sa[0]^sb[0]) & br)`.
  - Shift `sa` and `sb` right by 1.
  - Shift `d` into the result register from the MSB side.
  - Increment `cnt`.
  - When `cnt == WIDTH-1`, the edge processes the last bit: `diff` register complete, `borrow_out<=br_next`, go to DONE.
- **DONE**
  - `done=1` for exactly this cycle.
  - If `start` is high, reload exactly as in IDLE and go to RUN (back-to-back operation allowed).
  - Otherwise go to IDLE.
- **Output holding**:
  - `diff` and `borrow_out` hold their last result until the final edge of the next operation.
  - During RUN, `diff` shows the partially shifted value and is not valid.
- **`start` while in RUN**: ignored; no restart, no queueing.
- **Operand changes**: changes on `a`/`b` after the load edge have no effect.
- **Counter**: `cnt` is `$clog2(WIDTH)` bits wide and never wraps within an operation.

## Timing
- **Reset**: on any edge with `rst=1`, regardless of state (including mid-RUN), force state IDLE, `busy=0`, `done=0`, `diff=0`, `borrow_out=0`, `cnt=0`, `br=0`. `rst` has priority over `start`.
- **Load**: `start` accepted at edge E0; `busy=1` from after E0.
- **Bit processing**: bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
- **Completion**: after edge E_WIDTH, `busy=0`, `done=1`, and `diff`/`borrow_out` are valid.
- **Latency**: start edge to `done` is WIDTH edges; `done` is high during the cycle following E_WIDTH.
- **Throughput**: back-to-back issue with `start` held through DONE gives one result per WIDTH+1 cycles.
- **Output timing**: `busy` and `done` are registered outputs (no combinational path from `start`). `busy` and `done` are never high simultaneously.

## Configuration
- **`SERSUB_BORROW_IN_EN`**
  - Defined: adds port `borrow_in`, sampled with the operands on the load edge; the initial `br` is set to `borrow_in`, so the result is `a - b - borrow_in`. This allows multi-word chaining by feeding the previous `borrow_out`.
  - Undefined: the port is absent and the initial `br` is 0.

## Test plan
- WIDTH=8, `a=0x5A`, `b=0x3C`, pulse `start` -> `busy` high 8 cycles; `done` pulse on cycle 9 after the load edge; `diff=0x1E`, `borrow_out=0`.
- `a=0x00`, `b=0x01` -> `diff=0xFF`, `borrow_out=1`. `a=0x80`, `b=0x80` -> `diff=0x00`, `borrow_out=0`.
- `start` re-asserted and `a`/`b` changed at cycle 3 of RUN -> ignored; result equals the originally captured operands; `done` timing unchanged.
- Assert `rst` at cycle 4 of RUN -> next cycle all outputs are 0 and state is IDLE. A fresh `start` with `0x20 - 0x05` -> `diff=0x1B`.
- `start` held high continuously with operands `0x10-0x01`, then `0x01-0x02` -> `done` pulses 9 cycles apart; results `0x0F`/`borrow_out=0`, then `0xFF`/`borrow_out=1`.
- With `SERSUB_BORROW_IN_EN` defined: `a=0x10`, `b=0x01`, `borrow_in=1` -> `diff=0x0E`, `borrow_out=0`. `a=0x00`, `b=0x00`, `borrow_in=1` -> `diff=0xFF`, `borrow_out=1`.
